seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_scan_ctrl_hex7seg.sv | 11 +
 rtl/seg_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// scan FSM states, the all-segments-off pattern and the hex glyph table.
package seg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBlank,
      StDrive
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry [n] is the glyph for nibble n.
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_GLYPH[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered load interface.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned N_DIG        = 4,
   parameter int unsigned SLOT_CYCLES  = 3000,
   parameter int unsigned BLANK_CYCLES = 30
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic               LD_VALID,
   output logic               LD_READY,
   input  logic [4*N_DIG-1:0] LD_DATA,
   input  logic [N_DIG-1:0]   LD_DP,
   output logic [6:0]         SEG,
   output logic               DP,
   output logic [N_DIG-1:0]   AN,
   output logic               FRAME
);

   localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
   localparam int unsigned IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);

   if (!(BLANK_CYCLES > 0 && BLANK_CYCLES < SLOT_CYCLES)) begin : g_bad_params
      $error("seg_scan_ctrl: BLANK_CYCLES must satisfy 0 < BLANK_CYCLES < SLOT_CYCLES");
   end

   scan_state_e        state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic [4*N_DIG-1:0] pend_data_q, act_data_q;
   logic [N_DIG-1:0]   pend_dp_q, act_dp_q;
   logic               pend_full_q, pend_full_d;
   logic               ld_ready_q;
   logic [6:0]         seg_q;
   logic               dp_q;
   logic [N_DIG-1:0]   an_q;
   logic               frame_q;

   logic       boundary, ld_accept, xfer, lz_blank;
   logic [3:0] act_nib;
   logic [6:0] glyph;

   assign boundary  = (state_q == StDrive) && (idx_q == IDX_LAST) && (cnt_q == SLOT_LAST);
   assign ld_accept = LD_VALID && ld_ready_q;
   // While dark there is no frame to tear, so a full pending buffer moves over at once.
   assign xfer      = pend_full_q && (boundary || !EN);

   always_comb begin
      pend_full_d = pend_full_q;
      if (xfer) begin
         pend_full_d = 1'b0;
      end else if (ld_accept) begin
         pend_full_d = 1'b1;
      end
   end

   assign act_nib = act_data_q[{idx_q, 2'b00} +: 4];

   hex7seg u_hex7seg (
      .nibble_i (act_nib),
      .seg_o    (glyph)
   );

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [IDX_W-1:0] msd;

   // Highest nonzero digit; digit 0 is the floor so it always displays.
   always_comb begin
      msd = '0;
      for (int unsigned i = 1; i < N_DIG; i++) begin
         if (act_data_q[4*i +: 4] != 4'h0) begin
            msd = IDX_W'(i);
         end
      end
   end

   assign lz_blank = (idx_q > msd);
`else
   assign lz_blank = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         pend_full_q <= 1'b0;
         ld_ready_q  <= 1'b1;
      end else begin
         if (ld_accept) begin
            pend_data_q <= LD_DATA;
            pend_dp_q   <= LD_DP;
         end
         if (xfer) begin
            act_data_q <= pend_data_q;
            act_dp_q   <= pend_dp_q;
         end
         pend_full_q <= pend_full_d;
         ld_ready_q  <= !pend_full_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
         an_q    <= '1;
         frame_q <= 1'b0;
      end else begin
         frame_q <= boundary && EN;
         if (state_q == StDrive) begin
            an_q  <= ~(N_DIG'(1) << idx_q);
            seg_q <= lz_blank ? SEG_OFF : glyph;
            dp_q  <= lz_blank | ~act_dp_q[idx_q];
         end else begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
         end

         if (!EN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  state_q <= StBlank;
               end
               StBlank: begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == BLANK_LAST) begin
                     state_q <= StDrive;
                  end
               end
               StDrive: begin
                  if (cnt_q == SLOT_LAST) begin
                     cnt_q   <= '0;
                     state_q <= StBlank;
                     idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign LD_READY = ld_ready_q;
   assign SEG      = seg_q;
   assign DP       = dp_q;
   assign AN       = an_q;
   assign FRAME    = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (N_DIG=4, SLOT_CYCLES=8, BLANK_CYCLES=2).
// Each lit digit slot is popped from an expectation queue and compared.
module tb_seg_scan_ctrl;

   logic        CLK = 1'b0;
   logic        RST, EN, LD_VALID;
   logic        LD_READY;
   logic [15:0] LD_DATA;
   logic [3:0]  LD_DP;
   logic [6:0]  SEG;
   logic        DP;
   logic [3:0]  AN;
   logic        FRAME;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } slot_t;

   slot_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   bit    len_chk = 1'b1;

   seg_scan_ctrl #(
      .N_DIG        (4),
      .SLOT_CYCLES  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .EN       (EN),
      .LD_VALID (LD_VALID),
      .LD_READY (LD_READY),
      .LD_DATA  (LD_DATA),
      .LD_DP    (LD_DP),
      .SEG      (SEG),
      .DP       (DP),
      .AN       (AN),
      .FRAME    (FRAME)
   );

   initial forever #5 CLK = ~CLK;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_tests++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic push_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp);
      slot_t s;
      s.an  = an;
      s.seg = seg;
      s.dp  = dp;
      exp_q.push_back(s);
   endtask

   task automatic push_frame(input logic [15:0] data, input logic [3:0] dp);
      for (int d = 0; d < 4; d++) begin
         push_slot(~(4'b0001 << d), glyph(data[4*d +: 4]), ~dp[d]);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   task automatic wait_frame(input string name);
      int k;
      k = 0;
      do begin
         @(negedge CLK);
         k++;
      end while (!FRAME && k < 100);
      check(name, {31'd0, FRAME}, 32'd1);
   endtask

   // Monitor: a new lit slot pops one expectation; a finished slot must be 6 cycles long.
   initial begin : monitor
      logic       prev_lit;
      logic [3:0] prev_an;
      int         run_len;
      logic       lit;
      slot_t      e;
      prev_lit = 1'b0;
      prev_an  = 4'hF;
      run_len  = 0;
      forever begin
         @(negedge CLK);
         lit = !$isunknown(AN) && (AN != 4'hF);
         if (prev_lit && len_chk && (!lit || AN != prev_an)) begin
            n_tests++;
            if (run_len != 6) begin
               n_fail++;
               $display("FAIL slot_len: AN=%b lit %0d cycles, required 6", prev_an, run_len);
            end
         end
         if (lit && (!prev_lit || AN != prev_an)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL slot_unexpected: got AN=%b SEG=%h DP=%b, required no lit digit",
                        AN, SEG, DP);
            end else begin
               e = exp_q.pop_front();
               if ({AN, SEG, DP} !== e) begin
                  n_fail++;
                  $display("FAIL slot: got AN=%b SEG=%h DP=%b, required AN=%b SEG=%h DP=%b",
                           AN, SEG, DP, e.an, e.seg, e.dp);
               end
            end
            run_len = 1;
         end else if (lit) begin
            run_len++;
         end
         prev_lit = lit;
         prev_an  = AN;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int cnt;
      RST      = 1'b1;
      EN       = 1'b0;
      LD_VALID = 1'b0;
      LD_DATA  = '0;
      LD_DP    = '0;
      cycles(3);
      check("rst_seg",   {25'd0, SEG}, 32'h7F);
      check("rst_dp",    {31'd0, DP}, 32'd1);
      check("rst_an",    {28'd0, AN}, 32'hF);
      check("rst_frame", {31'd0, FRAME}, 32'd0);
      check("rst_ready", {31'd0, LD_READY}, 32'd1);

      // Load 1234 right after reset: one frame of zeros, then 1234.
      push_frame(16'h0000, 4'h0);
      push_frame(16'h1234, 4'h0);
      RST = 1'b0; EN = 1'b1; LD_VALID = 1'b1; LD_DATA = 16'h1234; LD_DP = 4'h0;
      @(negedge CLK);
      LD_VALID = 1'b0;
      check("ld_accept_ready_low", {31'd0, LD_READY}, 32'd0);
      wait_frame("frame1");
      check("ready_after_boundary", {31'd0, LD_READY}, 32'd1);
      wait_frame("frame2");
      EN = 1'b0;
      cycles(3);

      // Load A then hold B: A displays for one frame, then B.
      push_frame(16'h1234, 4'h0);
      push_frame(16'hABCD, 4'b0101);
      push_frame(16'h5678, 4'h0);
      EN = 1'b1; LD_VALID = 1'b1; LD_DATA = 16'hABCD; LD_DP = 4'b0101;
      @(negedge CLK);
      LD_DATA = 16'h5678; LD_DP = 4'h0;
      cnt = 0;
      while (!LD_READY && cnt < 100) begin
         cnt++;
         @(negedge CLK);
      end
      check("ready_low_cycles", cnt, 32'd32);
      check("ready_rise_with_frame", {31'd0, FRAME}, 32'd1);
      @(negedge CLK);
      LD_VALID = 1'b0;
      check("b_accepted", {31'd0, LD_READY}, 32'd0);
      wait_frame("frame_a");
      wait_frame("frame_b");
      EN = 1'b0;
      cycles(3);

      // EN falls mid-DRIVE of digit 0, then the scan restarts at digit 0.
      push_slot(4'b1110, 7'h00, 1'b1);
      len_chk = 1'b0;
      EN = 1'b1;
      cycles(5);
      EN = 1'b0;
      cycles(2);
      check("en_off_an",  {28'd0, AN}, 32'hF);
      check("en_off_seg", {25'd0, SEG}, 32'h7F);
      check("en_off_dp",  {31'd0, DP}, 32'd1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (FRAME) cnt++;
      end
      check("no_frame_idle_a", cnt, 32'd0);
      len_chk = 1'b1;
      push_frame(16'h5678, 4'h0);
      EN = 1'b1;
      wait_frame("frame_restart");
      EN = 1'b0;
      cycles(3);

      // FRAME period over 10 frames, then silence while disabled.
      for (int f = 0; f < 11; f++) push_frame(16'h5678, 4'h0);
      EN = 1'b1;
      wait_frame("frame_first");
      for (int p = 0; p < 10; p++) begin
         cnt = 0;
         do begin
            @(negedge CLK);
            cnt++;
         end while (!FRAME && cnt < 100);
         check($sformatf("frame_period_%0d", p), cnt, 32'd32);
      end
      EN = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (FRAME) cnt++;
      end
      check("no_frame_idle_b", cnt, 32'd0);

      // Reset mid-frame with a pending load: display falls back to zeros.
      push_slot(4'b1110, 7'h00, 1'b1);
      push_slot(4'b1101, 7'h78, 1'b1);
      len_chk = 1'b0;
      EN = 1'b1; LD_VALID = 1'b1; LD_DATA = 16'hEF90; LD_DP = 4'hF;
      @(negedge CLK);
      LD_VALID = 1'b0;
      cycles(11);
      RST = 1'b1;
      @(negedge CLK);
      check("midrst_seg",   {25'd0, SEG}, 32'h7F);
      check("midrst_an",    {28'd0, AN}, 32'hF);
      check("midrst_dp",    {31'd0, DP}, 32'd1);
      check("midrst_frame", {31'd0, FRAME}, 32'd0);
      check("midrst_ready", {31'd0, LD_READY}, 32'd1);
      push_frame(16'h0000, 4'h0);
      push_frame(16'h0000, 4'h0);
      RST = 1'b0;
      cycles(2);
      len_chk = 1'b1;
      wait_frame("frame_postrst1");
      wait_frame("frame_postrst2");
      EN = 1'b0;
      cycles(3);

      // Load while disabled transfers next cycle; leading zeros per build option.
      LD_VALID = 1'b1; LD_DATA = 16'h0050; LD_DP = 4'hF;
      @(negedge CLK);
      LD_VALID = 1'b0;
      check("dis_ready_low", {31'd0, LD_READY}, 32'd0);
      @(negedge CLK);
      check("dis_ready_high", {31'd0, LD_READY}, 32'd1);
      push_slot(4'b1110, 7'h40, 1'b0);
      push_slot(4'b1101, 7'h12, 1'b0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      push_slot(4'b1011, 7'h7F, 1'b1);
      push_slot(4'b0111, 7'h7F, 1'b1);
`else
      push_slot(4'b1011, 7'h40, 1'b0);
      push_slot(4'b0111, 7'h40, 1'b0);
`endif
      EN = 1'b1;
      wait_frame("frame_lz");
      EN = 1'b0;
      cycles(5);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
